// File: rtl/l1_mem_arbiter.sv
// -----------------------------------------------------------------------------
// l1_mem_arbiter
//   Shares the single MMU memory port between the L1 instruction cache
//   (read refills) and the L1 data cache (refills and write-throughs).
//   One requester is granted at a time. Its request is registered onto the
//   mmu_* outputs and held stable for the whole transaction. The MMU
//   completion pulse is passed straight back to the granted cache in the
//   same cycle. A transaction with no MMU response is aborted after
//   TIMEOUT_CYCLES grant cycles. Setting TIMEOUT_CYCLES to 0 disables the
//   timeout.
//
//   Optional feature macro: ARB_ROUND_ROBIN_EN
//     defined   : on simultaneous requests, the cache that did not win the
//                 previous grant wins. After reset the D-cache wins first.
//     undefined : fixed priority, the D-cache always wins conflicts.
//
// Ports
//   clk, reset_n                         clock (rising edge), async active-low reset
//   icache_req/_address                  I-cache read request, held until ready/error
//   icache_ready/_error/_data_out        I-cache completion / timeout pulses, read data
//   dcache_req/_we/_address/_data_in     D-cache request (read or write)
//   dcache_ready/_error/_data_out        D-cache completion / timeout pulses, read data
//   mmu_req/_we/_address/_data_in        registered request to the MMU
//   mmu_mem_ready/_data_out              MMU completion pulse and read data
// -----------------------------------------------------------------------------
module l1_mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  icache_req,
    input  logic [ADDR_WIDTH-1:0] icache_address,
    output logic                  icache_ready,
    output logic                  icache_error,
    output logic [DATA_WIDTH-1:0] icache_data_out,

    input  logic                  dcache_req,
    input  logic                  dcache_we,
    input  logic [ADDR_WIDTH-1:0] dcache_address,
    input  logic [DATA_WIDTH-1:0] dcache_data_in,
    output logic                  dcache_ready,
    output logic                  dcache_error,
    output logic [DATA_WIDTH-1:0] dcache_data_out,

    output logic                  mmu_req,
    output logic                  mmu_we,
    output logic [ADDR_WIDTH-1:0] mmu_address,
    output logic [DATA_WIDTH-1:0] mmu_data_in,
    input  logic                  mmu_mem_ready,
    input  logic [DATA_WIDTH-1:0] mmu_data_out
);

    // A zero-width counter is illegal, so the counter keeps one bit even when
    // the timeout is disabled.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  mmu_req_q, mmu_req_d;
    logic                  mmu_we_q, mmu_we_d;
    logic [ADDR_WIDTH-1:0] mmu_address_q, mmu_address_d;
    logic [DATA_WIDTH-1:0] mmu_data_in_q, mmu_data_in_d;

    logic                  d_wins;
    logic                  timeout_hit;

`ifdef ARB_ROUND_ROBIN_EN
    // 0 = I-cache won the last grant, 1 = D-cache won it.
    logic                  last_grant_q, last_grant_d;

    assign d_wins = ~last_grant_q;
`else
    assign d_wins = 1'b1;
`endif

    // The counter never passes TIMEOUT_CYCLES while the timeout is enabled,
    // because the arbiter leaves GRANT at that value.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mmu_req_d     = mmu_req_q;
        mmu_we_d      = mmu_we_q;
        mmu_address_d = mmu_address_q;
        mmu_data_in_d = mmu_data_in_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_d  = last_grant_q;
`endif

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (dcache_req && (!icache_req || d_wins)) begin
                    state_d       = GRANT_D;
                    mmu_req_d     = 1'b1;
                    mmu_we_d      = dcache_we;
                    mmu_address_d = dcache_address;
                    mmu_data_in_d = dcache_data_in;
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_d  = 1'b1;
`endif
                end else if (icache_req) begin
                    state_d       = GRANT_I;
                    mmu_req_d     = 1'b1;
                    mmu_we_d      = 1'b0;
                    mmu_address_d = icache_address;
                    mmu_data_in_d = '0;
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_d  = 1'b0;
`endif
                end else begin
                    mmu_req_d = 1'b0;
                end
            end

            GRANT_I, GRANT_D: begin
                // A completion in the timeout cycle wins over the abort.
                if (mmu_mem_ready || timeout_hit) begin
                    state_d   = IDLE;
                    mmu_req_d = 1'b0;
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d   = IDLE;
                mmu_req_d = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            mmu_req_q     <= 1'b0;
            mmu_we_q      <= 1'b0;
            mmu_address_q <= '0;
            mmu_data_in_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mmu_req_q     <= mmu_req_d;
            mmu_we_q      <= mmu_we_d;
            mmu_address_q <= mmu_address_d;
            mmu_data_in_q <= mmu_data_in_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Outputs: MMU request is registered; the completion path back to the
    // caches is combinational so the data arrives in the MMU ready cycle.
    // -------------------------------------------------------------------------
    assign mmu_req     = mmu_req_q;
    assign mmu_we      = mmu_we_q;
    assign mmu_address = mmu_address_q;
    assign mmu_data_in = mmu_data_in_q;

    assign icache_ready    = (state_q == GRANT_I) && mmu_mem_ready;
    assign icache_error    = (state_q == GRANT_I) && !mmu_mem_ready && timeout_hit;
    assign icache_data_out = icache_ready ? mmu_data_out : '0;

    assign dcache_ready    = (state_q == GRANT_D) && mmu_mem_ready;
    assign dcache_error    = (state_q == GRANT_D) && !mmu_mem_ready && timeout_hit;
    assign dcache_data_out = dcache_ready ? mmu_data_out : '0;

endmodule
